zbus_bridge: RTL
================

# zbus_bridge

Z80-to-68000 bus window controller for the FC1004 system. It turns a Z80 access in the 0x8000–0xFFFF window into one byte-wide 68k bus cycle. It holds the 9-bit bank register that supplies VA[23:15]. It acquires the 68k bus through the BR/BG/BGACK handshake, runs AS/UDS/LDS/DTACK, returns read data, and stalls the Z80 with WAIT until the cycle ends. It sits beside the bus arbiter and drives the shared VA/VD/strobe lines with the codebase tri-state convention: `_d` = 1 releases the line to input, 0 drives it.

## Interface
Parameters:
- `TIMEOUT_W`, default 7: width of the DTACK timeout counter. Timeout is 2^TIMEOUT_W enabled cycles.

Ports:
- `MCLK` in 1: system clock.
- `SRES` in 1: reset, asynchronous, active-low.
- `MCLK_e` in 1: clock enable. State changes only on `MCLK` edges with `MCLK_e`=1, called "cycles" below.
- `zreq` in 1: Z80 window access request, sampled in IDLE.
- `zwr` in 1: 1 = write, 0 = read. Latched with `zreq`.
- `za` in 15: Z80 address[14:0].
- `zd_i` in 8: Z80 write data.
- `bank_wr` in 1: one-cycle strobe for a bank register write (Z80 write to 0x6000).
- `zd_o` out 8: read data returned to the Z80.
- `zwait` out 1: 1 = hold the Z80 in wait.
- `zto` out 1: sticky flag, set when the last cycle timed out.
- `BR_pull` out 1: 1 = pull BR low.
- `BG` in 1: bus grant, active-low.
- `BGACK_pull` out 1: 1 = pull BGACK low.
- `AS_i` in 1: 68k address strobe, active-low. Used to detect a busy bus.
- `DTACK_i` in 1: data acknowledge, active-low.
- `AS_o`, `UDS_o`, `LDS_o`, `RW_o` out 1 each: 68k strobes, active-low. `RW_o` 1 = read.
- `strobe_d` out 1: direction for AS/UDS/LDS/RW.
- `VA_o` out 23: 68k word address[23:1].
- `VA_d` out 1: direction for `VA_o`.
- `VD_i` in 16: 68k data in.
- `VD_o` out 16: 68k data out.
- `VD_d` out 1: direction for `VD_o`.

## Operation
- Bank register `bank[8:0]`, reset value 0.
  - On an enabled `bank_wr`: `bank <= {zd_i[0], bank[8:1]}`.
  - The update applies in any state.
  - Target address = `{bank, za}` (24-bit byte address), latched at request acceptance.
  - A bank write during a transaction does not change the in-flight address.
- `VA_o` = latched addr[23:1].
- Byte lane: addr[0]=0 → UDS / `VD[15:8]`; addr[0]=1 → LDS / `VD[7:0]`.
- Write data: `VD_o = {zd, zd}`.
- FSM, one state per cycle unless a wait condition is noted:
  - IDLE: if `zreq`=1, latch address, data and `zwr`, clear `zto`, and go to REQ.
  - REQ: hold while (`BG`=1) or (`AS_i`=0) or (`DTACK_i`=0). Otherwise go to ADDR.
  - ADDR: goes to STROBE.
  - STROBE: goes to WAITACK.
  - WAITACK: on `DTACK_i`=0, latch the selected `VD_i` byte into `zd_o` and go to RELEASE. If the counter reaches 2^TIMEOUT_W first, set `zd_o`=8'hFF, set `zto`=1, and go to RELEASE.
  - RELEASE: goes to END.
  - END: goes to IDLE.
- Outputs are registered and decoded from state:
  - `zwait` = 1 in every state except IDLE.
  - `BR_pull` = 1 in REQ only.
  - `BGACK_pull` = 1 in ADDR through END.
  - `VA_d` = 0 and `strobe_d` = 0 in ADDR through RELEASE.
  - `RW_o` = ~zwr while driven.
  - `AS_o` = 0 and the selected UDS/LDS = 0 in STROBE and WAITACK. All strobes are 1 otherwise.
  - `VD_d` = 0 in STROBE and WAITACK on writes only.
- `zreq` outside IDLE is ignored.
- Reset values: state IDLE; `bank`=0; `zd_o`=8'hFF; `zwait`=0; `zto`=0; `BR_pull`=0; `BGACK_pull`=0; `AS_o`/`UDS_o`/`LDS_o`/`RW_o`=1; `strobe_d`=`VA_d`=`VD_d`=1; `VA_o`=0; `VD_o`=0.

## Timing
- `zreq` sampled at cycle n.
  - `zwait`=1 and `BR_pull`=1 from n+1.
  - Best case (BG already low, DTACK low at the first WAITACK sample): `zwait` returns to 0 at n+6. `zwait` is high for exactly 6 cycles.
- Each extra cycle spent in REQ or WAITACK adds one cycle to `zwait`.
- `zd_o` is valid from the cycle `zwait` falls and is held until the next accepted read.
- DTACK is ignored outside WAITACK.
- A DTACK still low in RELEASE/END does not extend the cycle.
- Timeout: the counter runs only in WAITACK and resets on entry.
  - With the default parameter, the exit occurs on the 128th WAITACK cycle.
  - Worst-case `zwait` with BG immediate = 133 cycles.
- `SRES` low at any time: all outputs return to reset values asynchronously and all lines are released. A partial 68k cycle is abandoned with no read data update.
- `MCLK_e`=0: no state, counter or register changes. Outputs hold.

## Test plan
- Bank load: 9 `bank_wr` with zd_i[0] = 1,0,0,0,0,0,0,0,1 (first→last) → bank=9'h101. A read of `za`=15'h1234 drives `VA_o` = 0x809234>>1 with UDS=0, LDS=1.
- Read, immediate grant: BG=0, DTACK=0 in WAITACK, `VD_i`=16'hA55A, `za`[0]=1 → `zd_o`=8'h5A, `zwait` high exactly 6 cycles, `BR_pull` high 1 cycle.
- Write, delayed grant: `zd_i`=8'h3C, BG held high for 10 cycles → `BR_pull` high 10 cycles, `BGACK_pull` not asserted until BG low, `VD_o`=16'h3C3C with `VD_d`=0 only during STROBE/WAITACK, `RW_o`=0.
- Timeout: DTACK never asserted → after 128 WAITACK cycles `zd_o`=8'hFF, `zto`=1. A following good read clears `zto`.
- Reset mid-WAITACK: `SRES` pulled low → same edge has `BR_pull`=`BGACK_pull`=0, `AS_o`=1, all `_d`=1, `zwait`=0, `bank`=0.
- Bank write during an active read → in-flight `VA_o` unchanged. The next access uses the new bank.

Source files
------------

// File: rtl/zbus_bridge.sv
// Z80 window to 68000 bus bridge: holds the VA[23:15] bank register, acquires the 68k bus,
// runs one byte-wide cycle per Z80 access and stalls the Z80 with zwait until it ends.
module zbus_bridge #(
  parameter int unsigned TIMEOUT_W = 7
) (
  input  logic        MCLK,
  input  logic        SRES,
  input  logic        MCLK_e,
  input  logic        zreq,
  input  logic        zwr,
  input  logic [14:0] za,
  input  logic [7:0]  zd_i,
  input  logic        bank_wr,
  output logic [7:0]  zd_o,
  output logic        zwait,
  output logic        zto,
  output logic        BR_pull,
  input  logic        BG,
  output logic        BGACK_pull,
  input  logic        AS_i,
  input  logic        DTACK_i,
  output logic        AS_o,
  output logic        UDS_o,
  output logic        LDS_o,
  output logic        RW_o,
  output logic        strobe_d,
  output logic [22:0] VA_o,
  output logic        VA_d,
  input  logic [15:0] VD_i,
  output logic [15:0] VD_o,
  output logic        VD_d
);

  typedef enum logic [2:0] {
    StIdle, StReq, StAddr, StStrobe, StWaitAck, StRelease, StEnd
  } state_e;

  state_e               state_q, state_d;
  logic [8:0]           bank_q;
  logic [23:0]          addr_q;
  logic [7:0]           data_q;
  logic                 zwr_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 drive, strb;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (zreq) state_d = StReq;
      // Wait for the grant and for the previous master to finish its cycle
      StReq:     if (!BG && AS_i && DTACK_i) state_d = StAddr;
      StAddr:    state_d = StStrobe;
      StStrobe:  state_d = StWaitAck;
      StWaitAck: if (!DTACK_i || (cnt_q == '1)) state_d = StRelease;
      StRelease: state_d = StEnd;
      StEnd:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output levels are decoded from the next state so they change with the state register.
  assign drive = (state_d == StAddr) || (state_d == StStrobe) ||
                 (state_d == StWaitAck) || (state_d == StRelease);
  assign strb  = (state_d == StStrobe) || (state_d == StWaitAck);

  assign VA_o = addr_q[23:1];
  assign VD_o = {data_q, data_q};

  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      state_q    <= StIdle;
      bank_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      zwr_q      <= 1'b0;
      cnt_q      <= '0;
      zd_o       <= 8'hFF;
      zwait      <= 1'b0;
      zto        <= 1'b0;
      BR_pull    <= 1'b0;
      BGACK_pull <= 1'b0;
      AS_o       <= 1'b1;
      UDS_o      <= 1'b1;
      LDS_o      <= 1'b1;
      RW_o       <= 1'b1;
      strobe_d   <= 1'b1;
      VA_d       <= 1'b1;
      VD_d       <= 1'b1;
    end else if (MCLK_e) begin
      state_q <= state_d;

      if (bank_wr) bank_q <= {zd_i[0], bank_q[8:1]};

      if ((state_q == StIdle) && zreq) begin
        addr_q <= {bank_q, za};
        data_q <= zd_i;
        zwr_q  <= zwr;
        zto    <= 1'b0;
      end

      if (state_q == StWaitAck) begin
        cnt_q <= cnt_q + TIMEOUT_W'(1);
        if (!DTACK_i) begin
          if (!zwr_q) zd_o <= addr_q[0] ? VD_i[7:0] : VD_i[15:8];
        end else if (cnt_q == '1) begin
          zto <= 1'b1;
          if (!zwr_q) zd_o <= 8'hFF;
        end
      end else begin
        cnt_q <= '0;
      end

      zwait      <= (state_d != StIdle);
      BR_pull    <= (state_d == StReq);
      BGACK_pull <= drive || (state_d == StEnd);
      VA_d       <= ~drive;
      strobe_d   <= ~drive;
      RW_o       <= drive ? ~zwr_q : 1'b1;
      AS_o       <= ~strb;
      UDS_o      <= ~(strb && !addr_q[0]);
      LDS_o      <= ~(strb && addr_q[0]);
      VD_d       <= ~(strb && zwr_q);
    end
  end

endmodule
